if_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the IF stage. Owns the PC and drives the
//  req/ack handshake to the instruction ROM. Presents each fetched word to the
//  IF/ID register with a valid/stall handshake, and redirects the PC on branches.

---
 rtl/if_ctrl.sv | 165 ++++++++++++++++
 tb/tb_if_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/if_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : if_ctrl
//  Purpose  : IF-stage fetch sequencer: PC ownership, ROM req/ack, IF/ID
//             valid/stall handshake with one-entry skid, branch redirect.
//  Revision : 1.0
// ============================================================================
module if_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [31:0]       branch_tgt_i,
    output logic              rom_req_o,
    output logic [31:0]       rom_addr_o,
    input  logic              rom_ack_i,
    input  logic [INST_W-1:0] rom_data_i,
    output logic [INST_W-1:0] inst_o,
    output logic [31:0]       pc_o,
    output logic              inst_valid_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       addr_q, addr_d;
    logic              req_q, req_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [31:0]       pco_q, pco_d;
    logic              valid_q, valid_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic [31:0]       skid_pc_q, skid_pc_d;

    logic [31:0]       tgt;
    logic [31:0]       pc_inc;
    logic              slot_free;

    assign tgt       = {branch_tgt_i[31:2], 2'b00};
    assign pc_inc    = pc_q + 32'd4;
    assign slot_free = !valid_q || !stall_i;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        req_d       = req_q;
        inst_d      = inst_q;
        pco_d       = pco_q;
        valid_d     = valid_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;

        if (valid_q && !stall_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                req_d   = 1'b1;
                if (branch_i) begin
                    pc_d   = tgt;
                    addr_d = tgt;
                end else begin
                    addr_d = pc_q;
                end
            end
            S_REQ: begin
                if (branch_i) begin
                    pc_d    = tgt;
                    valid_d = 1'b0;
                    if (rom_ack_i) begin
                        addr_d = tgt;
                    end else begin
                        // Request cannot be aborted: wait out its ack first.
                        state_d = S_DRAIN;
                    end
                end else if (rom_ack_i) begin
                    pc_d = pc_inc;
                    if (slot_free) begin
                        inst_d  = rom_data_i;
                        pco_d   = pc_q;
                        valid_d = 1'b1;
                        addr_d  = pc_inc;
                    end else begin
                        skid_inst_d = rom_data_i;
                        skid_pc_d   = pc_q;
                        req_d       = 1'b0;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_DRAIN: begin
                if (branch_i) begin
                    pc_d    = tgt;
                    valid_d = 1'b0;
                end
                if (rom_ack_i) begin
                    state_d = S_REQ;
                    addr_d  = branch_i ? tgt : pc_q;
                end
            end
            S_HOLD: begin
                if (branch_i) begin
                    pc_d    = tgt;
                    valid_d = 1'b0;
                    addr_d  = tgt;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end else if (!stall_i) begin
                    inst_d  = skid_inst_q;
                    pco_d   = skid_pc_q;
                    valid_d = 1'b1;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            req_q       <= 1'b0;
            inst_q      <= '0;
            pco_q       <= '0;
            valid_q     <= 1'b0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            inst_q      <= inst_d;
            pco_q       <= pco_d;
            valid_q     <= valid_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign rom_req_o    = req_q;
    assign rom_addr_o   = addr_q;
    assign inst_o       = inst_q;
    assign pc_o         = pco_q;
    assign inst_valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_if_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_ctrl
//  Purpose  : Directed self-checking bench for if_ctrl with a ROM model
//             (mem[i]=i) of programmable ack delay.
//  Revision : 1.0
// ============================================================================
module tb_if_ctrl;

    localparam int INST_W = 32;

    logic              clk;
    logic              rst;
    logic              rst2;
    logic              stall_i;
    logic              branch_i;
    logic [31:0]       branch_tgt_i;
    logic              rom_req_o, rom_ack_i;
    logic [31:0]       rom_addr_o;
    logic [INST_W-1:0] rom_data_i, inst_o;
    logic [31:0]       pc_o;
    logic              inst_valid_o;

    logic              req2, ack2, valid2;
    logic [31:0]       addr2, pc2;
    logic [INST_W-1:0] data2, inst2;

    logic [3:0]        ack_cnt;
    logic [3:0]        ack_delay;

    int n_checks = 0;
    int n_errors = 0;

    if_ctrl #(.RESET_PC(32'h0000_0000), .INST_W(INST_W)) u_dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_i(branch_i),
        .branch_tgt_i(branch_tgt_i), .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o),
        .rom_ack_i(rom_ack_i), .rom_data_i(rom_data_i), .inst_o(inst_o),
        .pc_o(pc_o), .inst_valid_o(inst_valid_o)
    );

    if_ctrl #(.RESET_PC(32'hFFFF_FFF8), .INST_W(INST_W)) u_dut_wrap (
        .clk(clk), .rst(rst2), .stall_i(stall_i), .branch_i(branch_i),
        .branch_tgt_i(branch_tgt_i), .rom_req_o(req2), .rom_addr_o(addr2),
        .rom_ack_i(ack2), .rom_data_i(data2), .inst_o(inst2),
        .pc_o(pc2), .inst_valid_o(valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: ack after ack_delay waiting cycles of a held request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_cnt <= '0;
        end else if (rom_req_o && !rom_ack_i) begin
            ack_cnt <= ack_cnt + 4'd1;
        end else begin
            ack_cnt <= '0;
        end
    end
    assign rom_ack_i  = rom_req_o && (ack_cnt >= ack_delay);
    assign rom_data_i = rom_addr_o >> 2;
    assign ack2       = req2;
    assign data2      = addr2 >> 2;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_inst);
        check_eq({tag, ".valid"}, {31'd0, inst_valid_o}, 32'd1);
        check_eq({tag, ".pc"}, pc_o, exp_pc);
        check_eq({tag, ".inst"}, inst_o, exp_inst);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; rst2 = 1'b0; stall_i = 1'b0; branch_i = 1'b0;
        branch_tgt_i = '0; ack_delay = 4'd0;
        tick(); tick();
        check_eq("rst.req", {31'd0, rom_req_o}, 32'd0);
        check_eq("rst.addr", rom_addr_o, 32'h0);
        check_eq("rst.valid", {31'd0, inst_valid_o}, 32'd0);
        check_eq("rst.pc", pc_o, 32'h0);
        check_eq("rst.inst", inst_o, 32'h0);
        check_eq("rst2.addr", addr2, 32'hFFFF_FFF8);

        // Zero-wait streaming
        rst = 1'b1;
        tick();
        check_eq("lat.req", {31'd0, rom_req_o}, 32'd1);
        check_eq("lat.valid", {31'd0, inst_valid_o}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("stream", 32'(4 * i), 32'(i));
        end

        // Stall 5 cycles with pc_o=16 held
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("stall", 32'd16, 32'd4);
            check_eq("stall.req", {31'd0, rom_req_o}, 32'd0);
        end
        stall_i = 1'b0;
        tick(); check_out("unstall0", 32'd20, 32'd5);
        tick(); check_out("unstall1", 32'd24, 32'd6);

        // Three-cycle ack delay: address stable 4 cycles per word
        ack_delay = 4'd3;
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                check_eq("dly.valid", {31'd0, inst_valid_o}, 32'd0);
                check_eq("dly.addr", rom_addr_o, 32'(28 + 4 * w));
            end
            tick();
            check_out("dly", 32'(28 + 4 * w), 32'(7 + w));
        end

        // Branch to 0x100 while request for 36 is still pending
        tick();
        branch_i = 1'b1; branch_tgt_i = 32'h100;
        tick();
        branch_i = 1'b0;
        check_eq("drain.req", {31'd0, rom_req_o}, 32'd1);
        check_eq("drain.addr", rom_addr_o, 32'd36);
        check_eq("drain.valid", {31'd0, inst_valid_o}, 32'd0);
        tick();
        check_eq("drain2.addr", rom_addr_o, 32'd36);
        check_eq("drain2.valid", {31'd0, inst_valid_o}, 32'd0);
        tick();
        check_eq("redir.addr", rom_addr_o, 32'h100);
        for (int k = 0; k < 4; k++) begin
            check_eq("redir.valid", {31'd0, inst_valid_o}, 32'd0);
            tick();
        end
        check_out("redir", 32'h100, 32'h40);

        // Branch coincident with ack, unaligned target
        ack_delay = 4'd0;
        branch_i = 1'b1; branch_tgt_i = 32'h203;
        tick();
        branch_i = 1'b0;
        check_eq("bra.valid", {31'd0, inst_valid_o}, 32'd0);
        check_eq("bra.addr", rom_addr_o, 32'h200);
        tick(); check_out("bra0", 32'h200, 32'h80);
        tick(); check_out("bra1", 32'h204, 32'h81);

        // Branch while in HOLD discards the skid word
        stall_i = 1'b1;
        tick();
        check_eq("hold.req", {31'd0, rom_req_o}, 32'd0);
        check_out("hold", 32'h204, 32'h81);
        branch_i = 1'b1; branch_tgt_i = 32'h300;
        tick();
        branch_i = 1'b0; stall_i = 1'b0;
        check_eq("hbr.valid", {31'd0, inst_valid_o}, 32'd0);
        check_eq("hbr.addr", rom_addr_o, 32'h300);
        tick(); check_out("hbr", 32'h300, 32'hC0);

        // Asynchronous reset in the middle of a pending request
        ack_delay = 4'd3;
        tick();
        check_eq("pend.req", {31'd0, rom_req_o}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("arst.req", {31'd0, rom_req_o}, 32'd0);
        check_eq("arst.valid", {31'd0, inst_valid_o}, 32'd0);
        check_eq("arst.pc", pc_o, 32'h0);
        check_eq("arst.inst", inst_o, 32'h0);
        check_eq("arst.addr", rom_addr_o, 32'h0);
        ack_delay = 4'd0;
        tick();
        rst = 1'b1; rst2 = 1'b1;
        tick();
        check_eq("rel.addr2", addr2, 32'hFFFF_FFF8);
        tick();
        check_out("rel", 32'h0, 32'h0);
        check_eq("wrap0.pc", pc2, 32'hFFFF_FFF8);
        check_eq("wrap0.inst", inst2, 32'h3FFF_FFFE);
        tick();
        check_eq("wrap1.pc", pc2, 32'hFFFF_FFFC);
        check_eq("wrap1.inst", inst2, 32'h3FFF_FFFF);
        tick();
        check_eq("wrap2.pc", pc2, 32'h0000_0000);
        check_eq("wrap2.inst", inst2, 32'h0);
        check_eq("wrap2.valid", {31'd0, valid2}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
